// File: rtl/spi_period_rx.sv
// spi_period_rx: SPI slave receiving three note periods from the PIC.
// Pins are synchronised into clk; prd1..prd3 update together only after a
// complete frame of exactly NUM_W*PERIOD_W bits, MSB first (prd1 first).
// Optional macro SPI_ECHO_EN: sdo shifts out the last committed periods.
module spi_period_rx #(
    parameter int PERIOD_W = 33,
    parameter int NUM_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                sdi,
    input  logic                load,
    output logic                sdo,
    output logic [PERIOD_W-1:0] prd1,
    output logic [PERIOD_W-1:0] prd2,
    output logic [PERIOD_W-1:0] prd3,
    output logic                prd_valid,
    output logic                frame_err
);
    localparam int N  = NUM_W * PERIOD_W;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ERROR} state_t;

    state_t              state_q, state_d;
    logic [2:0]          sck_q, sck_d;
    logic [2:0]          load_q, load_d;
    logic [1:0]          sdi_q, sdi_d;
    logic [N-1:0]        shreg_q, shreg_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic [PERIOD_W-1:0] prd1_q, prd1_d, prd2_q, prd2_d, prd3_q, prd3_d;
    logic                prd_valid_q, prd_valid_d, frame_err_q, frame_err_d;
    logic                sck_rise, load_fall;

    // Two-flop synchronisers plus one history flop for edge detection on sck/load
    always_comb begin
        sck_d     = {sck_q[1:0], sck};
        load_d    = {load_q[1:0], load};
        sdi_d     = {sdi_q[0], sdi};
        sck_rise  = sck_q[1] & ~sck_q[2];
        load_fall = ~load_q[1] & load_q[2];
    end

    // Frame FSM: collect bits while load is high, commit or discard when it drops
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        prd1_d      = prd1_q;
        prd2_d      = prd2_q;
        prd3_d      = prd3_q;
        prd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_q[1]) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (load_fall) begin
                    state_d = (bitcnt_q == CW'(N)) ? COMMIT : ERROR;
                end else if (sck_rise && load_q[1]) begin
                    shreg_d  = {shreg_q[N-2:0], sdi_q[1]};
                    bitcnt_d = (bitcnt_q == CW'(N + 1)) ? bitcnt_q : bitcnt_q + 1'b1;
                end
            end
            COMMIT: begin
                prd1_d      = shreg_q[N-1 -: PERIOD_W];
                prd2_d      = shreg_q[N-1-PERIOD_W -: PERIOD_W];
                prd3_d      = shreg_q[PERIOD_W-1:0];
                prd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            ERROR: begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sck_q       <= '0;
            load_q      <= '0;
            sdi_q       <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            prd1_q      <= '0;
            prd2_q      <= '0;
            prd3_q      <= '0;
            prd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_d;
            load_q      <= load_d;
            sdi_q       <= sdi_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            prd1_q      <= prd1_d;
            prd2_q      <= prd2_d;
            prd3_q      <= prd3_d;
            prd_valid_q <= prd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SPI_ECHO_EN
    logic [N-1:0] echo_q, echo_d;

    // Echo register: snapshot committed periods at frame start, shift on sck falls
    always_comb begin
        echo_d = echo_q;
        if (state_q == IDLE && load_q[1])
            echo_d = {prd1_q, prd2_q, prd3_q};
        else if (state_q == SHIFT && load_q[1] && ~sck_q[1] && sck_q[2])
            echo_d = {echo_q[N-2:0], 1'b0};
    end

    // Echo shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) echo_q <= '0;
        else       echo_q <= echo_d;
    end

    assign sdo = (state_q == SHIFT) & load_q[1] & echo_q[N-1];
`else
    assign sdo = 1'b0;
`endif

    assign prd1      = prd1_q;
    assign prd2      = prd2_q;
    assign prd3      = prd3_q;
    assign prd_valid = prd_valid_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_period_rx.sv
// tb_spi_period_rx: randomized frames checked every cycle against a frame-level model.
module tb_spi_period_rx;
    localparam int W = 33;
    localparam int N = 99;

    logic         clk = 1'b0;
    logic         reset, sck, sdi, load, sdo, prd_valid, frame_err;
    logic [W-1:0] prd1, prd2, prd3;

    spi_period_rx dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load), .sdo(sdo),
        .prd1(prd1), .prd2(prd2), .prd3(prd3), .prd_valid(prd_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int           checks = 0, errors = 0, cyc = 0, n_valid = 0, n_err = 0;
    logic [W-1:0] m_prd [3] = '{default: '0};
    logic [W-1:0] pend_val [3];
    logic         pend_on = 1'b0, pend_good = 1'b0, ev, ee;
    int           pend_cyc = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle comparison against the frame-level model
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        ev = pend_on && cyc == pend_cyc && pend_good;
        ee = pend_on && cyc == pend_cyc && !pend_good;
        if (ev) for (int i = 0; i < 3; i++) m_prd[i] = pend_val[i];
        if (pend_on && cyc == pend_cyc) pend_on = 1'b0;
        chk("prd_valid", W'(prd_valid), W'(ev));
        chk("frame_err", W'(frame_err), W'(ee));
        chk("prd1", prd1, m_prd[0]);
        chk("prd2", prd2, m_prd[1]);
        chk("prd3", prd3, m_prd[2]);
`ifndef SPI_ECHO_EN
        chk("sdo_tied", W'(sdo), '0);
`endif
        n_valid += int'(prd_valid);
        n_err   += int'(frame_err);
    end

    // One frame: nbits sck pulses at f_clk/8; extra bits beyond 99 are random.
    // coincide=1 adds an sck rise on the same clk as the load fall (must be ignored).
    task automatic send_frame(input logic [W-1:0] a, b, c, input int nbits, input bit coincide);
        logic [N-1:0] s, ex;
        s  = {a, b, c};
        ex = '0;
        load = 1'b1;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < N) ? s[N-1-i] : 1'($urandom);
            tick(4);
`ifdef SPI_ECHO_EN
            if (i == 0) ex = {m_prd[0], m_prd[1], m_prd[2]};
            if (i < N) chk("sdo_echo", W'(sdo), W'(ex[N-1-i]));
`endif
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        sdi = 1'($urandom);
        tick(4);
        if (coincide) sck = 1'b1;
        load        = 1'b0;
        pend_on     = 1'b1;
        pend_cyc    = cyc + 4;
        pend_good   = (nbits == N);
        pend_val[0] = a;
        pend_val[1] = b;
        pend_val[2] = c;
        if (coincide) begin
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic idle_sck(input int n);
        for (int i = 0; i < n; i++) begin
            sdi = 1'($urandom);
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {1'($urandom), $urandom};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int v0, e0, len, r;
        logic [W-1:0] a, b, c;
        reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
        tick(3);
        chk("rst_prd1", prd1, '0);
        chk("rst_valid", W'(prd_valid), '0);
        reset = 1'b0;
        tick(4);

        v0 = n_valid;
        send_frame(33'h0_0001_7C30, 33'h0_0000_BE18, 33'h1_0000_0001, N, 1'b0);
        tick(8);
        chk("t2_prd1", prd1, 33'h0_0001_7C30);
        chk("t2_prd2", prd2, 33'h0_0000_BE18);
        chk("t2_prd3", prd3, 33'h1_0000_0001);
        chk("t2_pulses", W'(n_valid - v0), W'(1));

        v0 = n_valid; e0 = n_err;
        send_frame(rnd(), rnd(), rnd(), 98, 1'b0);
        tick(8);
        chk("t3_prd1", prd1, 33'h0_0001_7C30);
        chk("t3_errs", W'(n_err - e0), W'(1));
        chk("t3_pulses", W'(n_valid - v0), '0);

        e0 = n_err;
        send_frame(rnd(), rnd(), rnd(), 100, 1'b0);
        tick(8);
        chk("t4_prd3", prd3, 33'h1_0000_0001);
        chk("t4_errs", W'(n_err - e0), W'(1));

        v0 = n_valid;
        send_frame(33'h0_1234_5678, 33'h1_8765_4321, 33'h0_0000_0007, N, 1'b0);
        tick(4);
        send_frame(33'h1_FFFF_FFFF, 33'h0_0000_0000, 33'h0_ABCD_EF01, N, 1'b0);
        tick(8);
        chk("t5_pulses", W'(n_valid - v0), W'(2));
        chk("t5_prd1", prd1, 33'h1_FFFF_FFFF);
        chk("t5_prd2", prd2, 33'h0_0000_0000);
        chk("t5_prd3", prd3, 33'h0_ABCD_EF01);

        v0 = n_valid;
        send_frame(33'h0_0000_0000, 33'h0_0000_0000, 33'h0_0000_0000, N, 1'b1);
        tick(8);
        chk("coinc_pulses", W'(n_valid - v0), W'(1));
        chk("zero_prd1", prd1, '0);

        v0 = n_valid; e0 = n_err;
        idle_sck(5);
        tick(4);
        chk("idle_sck_events", W'(n_valid - v0 + n_err - e0), '0);

        for (int k = 0; k < 25; k++) begin
            r   = int'($urandom_range(0, 5));
            len = (r < 3) ? N : (r == 3) ? 98 : (r == 4) ? 100 : int'($urandom_range(0, 110));
            a = rnd(); b = rnd(); c = rnd();
            send_frame(a, b, c, len, 1'($urandom_range(0, 3) == 0));
            tick(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 4) == 0) idle_sck(int'($urandom_range(1, 3)));
        end
        tick(8);

        send_frame(33'h0_0F0F_0F0F, 33'h1_0101_0101, 33'h0_7777_7777, N, 1'b0);
        tick(8);
        load = 1'b1;
        tick(4);
        idle_sck(20);
        reset = 1'b1; load = 1'b0; sck = 1'b0;
        pend_on = 1'b0;
        for (int i = 0; i < 3; i++) m_prd[i] = '0;
        tick(2);
        chk("midrst_prd1", prd1, '0);
        chk("midrst_prd2", prd2, '0);
        reset = 1'b0;
        v0 = n_valid; e0 = n_err;
        tick(20);
        chk("midrst_events", W'(n_valid - v0 + n_err - e0), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
